// File: rtl/p_s_pkg.sv
// Shared constants for the p_s / s_p serial link.
// Word geometry and the 1-bit FSM encoding.
package p_s_pkg;
   localparam int WORD_W    = 34;
   localparam int NUM_WORDS = 4;
   localparam int FRAME_W   = WORD_W * NUM_WORDS;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
endpackage

// File: rtl/p_s.sv
// Parallel-to-serial converter: one frame in, NUM_WORDS words out.
// Word 0 (lowest bits) goes first so s_p can rebuild the frame.
module p_s #(
   parameter int  WORD_W    = p_s_pkg::WORD_W,
   parameter int  NUM_WORDS = p_s_pkg::NUM_WORDS,
   localparam int FRAME_W   = WORD_W * NUM_WORDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FRAME_W-1:0] data_in_1,
   input  logic               p_s_valid_in,
   output logic               p_s_ready_out,
   output logic [WORD_W-1:0]  data_out_1,
   output logic               p_s_flag_out,
   output logic               p_s_last_out,
   input  logic               p_s_ready_in
);
   import p_s_pkg::*;

   localparam int REST_W = FRAME_W - WORD_W;
   localparam int CNT_W  = $clog2(NUM_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   logic [0:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [REST_W-1:0] rest;
   logic              frame_acc;
   logic              word_acc;
   logic              at_last;

   assign at_last   = (cnt == LAST_CNT);
   assign frame_acc = p_s_valid_in & p_s_ready_out;
   assign word_acc  = p_s_flag_out & p_s_ready_in;

   // A new frame may enter in the same cycle the last word leaves.
   assign p_s_ready_out = (state == IDLE)
                        | ((state == SEND) & at_last & p_s_ready_in);
   assign p_s_last_out  = p_s_flag_out & at_last;

   // data_out_1 holds the current word; rest holds the words still to go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         rest         <= '0;
         data_out_1   <= '0;
         p_s_flag_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (frame_acc) begin
                  data_out_1   <= data_in_1[WORD_W-1:0];
                  rest         <= data_in_1[FRAME_W-1:WORD_W];
                  cnt          <= '0;
                  p_s_flag_out <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (word_acc) begin
                  if (!at_last) begin
                     cnt        <= cnt + 1'b1;
                     data_out_1 <= rest[WORD_W-1:0];
                     rest       <= rest >> WORD_W;
                  end else if (frame_acc) begin
                     data_out_1 <= data_in_1[WORD_W-1:0];
                     rest       <= data_in_1[FRAME_W-1:WORD_W];
                     cnt        <= '0;
                  end else begin
                     cnt          <= '0;
                     p_s_flag_out <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_p_s.sv
// Self-checking bench for p_s: directed cases plus random traffic
// checked against a word-queue model of the serial stream.
module tb_p_s;
   localparam int W  = 34;
   localparam int N  = 4;
   localparam int FW = W * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] data_in_1 = '0;
   logic          p_s_valid_in = 1'b0;
   logic          p_s_ready_out;
   logic [W-1:0]  data_out_1;
   logic          p_s_flag_out;
   logic          p_s_last_out;
   logic          p_s_ready_in = 1'b0;

   p_s dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in_1     (data_in_1),
      .p_s_valid_in  (p_s_valid_in),
      .p_s_ready_out (p_s_ready_out),
      .data_out_1    (data_out_1),
      .p_s_flag_out  (p_s_flag_out),
      .p_s_last_out  (p_s_last_out),
      .p_s_ready_in  (p_s_ready_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: queue of words still owed to the link, in send order.
   logic [W-1:0] exp_q[$];
   int           hold_prev = 0;
   logic [W-1:0] hold_data = '0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      f = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return f;
   endfunction

   // One clock: drive at negedge, check, then advance the model.
   task automatic cyc(input logic v, input logic [FW-1:0] d,
                      input logic r, output logic acc);
      int   pend;
      logic exp_rdy;
      @(negedge clk);
      p_s_valid_in = v;
      data_in_1    = d;
      p_s_ready_in = r;
      #1;
      pend    = exp_q.size();
      exp_rdy = (pend == 0) || (pend == 1 && r);
      check("ready_out", p_s_ready_out, exp_rdy);
      check("flag", p_s_flag_out, pend > 0);
      check("last", p_s_last_out, pend == 1);
      if (hold_prev != 0)
         check("hold_data", data_out_1, hold_data);
      hold_prev = (pend > 0 && !r) ? 1 : 0;
      hold_data = data_out_1;
      if (pend > 0 && r) begin
         check("word", data_out_1, exp_q[0]);
         void'(exp_q.pop_front());
      end
      acc = v && exp_rdy;
      if (acc)
         for (int i = 0; i < N; i++)
            exp_q.push_back(d[i*W +: W]);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_data", data_out_1, 0);
      check("rst_flag", p_s_flag_out, 0);
      check("rst_last", p_s_last_out, 0);
      check("rst_ready", p_s_ready_out, 1);
      exp_q.delete();
      hold_prev = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   logic [W-1:0]  w[4];
   logic [FW-1:0] f0, fa, fb, cur;
   logic          acc;
   logic          have;
   int            nfr, nflag, nrdy, guard;

   initial begin
      w[0] = 34'h3DEADBEEF;
      w[1] = 34'h012345678;
      w[2] = 34'h155555555;
      w[3] = 34'h3AAAAAAAA;
      f0 = {w[3], w[2], w[1], w[0]};

      #12;
      check("init_data", data_out_1, 0);
      check("init_flag", p_s_flag_out, 0);
      check("init_ready", p_s_ready_out, 1);
      rst_n = 1'b1;

      // Single frame, link always ready; word values from constants.
      cyc(1'b1, f0, 1'b1, acc);
      check("single_acc", acc, 1);
      for (int i = 0; i < N; i++) begin
         cyc(1'b0, '0, 1'b1, acc);
         check("single_word", data_out_1, w[i]);
         check("single_last", p_s_last_out, i == N - 1);
      end
      cyc(1'b0, '0, 1'b1, acc);
      check("single_done", p_s_flag_out, 0);

      // Backpressure during word 1.
      fa = rand_frame();
      cyc(1'b1, fa, 1'b1, acc);
      cyc(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, 1'b0, acc);
         check("bp_word1", data_out_1, fa[W +: W]);
      end
      for (int i = 0; i < 4; i++)
         cyc(1'b0, '0, 1'b1, acc);

      // Back-to-back frames with valid held high.
      fa = rand_frame();
      fb = rand_frame();
      nfr = 0; nflag = 0; nrdy = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(nfr < 2, (nfr == 0) ? fa : fb, 1'b1, acc);
         if (p_s_flag_out) nflag++;
         if (p_s_ready_out) nrdy++;
         if (acc) nfr++;
      end
      check("b2b_frames", nfr, 2);
      check("b2b_flags", nflag, 8);
      check("b2b_ready", nrdy, 4);

      // Reset after word 2 left, then a fresh frame.
      fa = rand_frame();
      cyc(1'b1, fa, 1'b1, acc);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, '0, 1'b1, acc);
      reset_mid();
      fb = rand_frame();
      cyc(1'b1, fb, 1'b1, acc);
      cyc(1'b0, '0, 1'b1, acc);
      check("rst_new_w0", data_out_1, fb[W-1:0]);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, '0, 1'b1, acc);

      // Random traffic: producer holds its frame until accepted.
      have = 1'b0;
      cur  = '0;
      nfr  = 0;
      for (int i = 0; i < 800; i++) begin
         if (!have) begin
            cur  = rand_frame();
            have = 1'b1;
         end
         cyc(($urandom % 10) < 7, cur, ($urandom % 4) != 0, acc);
         if (acc) begin
            have = 1'b0;
            nfr++;
         end
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         cyc(1'b0, '0, 1'b1, acc);
         guard++;
      end
      check("drain", exp_q.size(), 0);
      check("rand_frames_seen", nfr > 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
